// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the word-wide, byte-addressed data memory.
// Takes one load/store at a time and returns one response per request.
// Sub-word stores are done as read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword
// and word accesses return an error. When it is undefined, the low address bits
// are forced to zero and the access goes ahead.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    typedef enum logic [2:0] {
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } op_t;

    state_t      state, state_next;
    op_t         in_op, lat_op;
    logic [1:0]  lat_lane;
    logic [15:0] lat_wdata;
    logic        accept;

    logic        in_half, in_word;
    logic [2:0]  in_size;
    logic [32:0] in_end;
    logic        in_range_err, in_misalign, in_err;
    logic [31:0] in_addr_eff;
    logic        lat_is_load;

    logic        nxt_mem_read, nxt_mem_write, nxt_resp_valid, nxt_resp_err;
    logic [31:0] nxt_mem_address, nxt_mem_data_in, nxt_resp_rdata;

    // Extract and extend the loaded byte/halfword at the given lane.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input op_t op,
                                                 input logic [1:0] lane);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (op)
            OP_LB:   res = {{24{sh[7]}}, sh[7:0]};
            OP_LH:   res = {{16{sh[15]}}, sh[15:0]};
            OP_LBU:  res = {24'b0, sh[7:0]};
            OP_LHU:  res = {16'b0, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the selected byte/halfword lane of the read word with store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input op_t op,
                                                input logic [1:0] lane,
                                                input logic [15:0] wdata);
        logic [31:0] mask;
        logic [31:0] data;
        if (op == OP_SH) begin
            mask = 32'h0000_FFFF << {lane, 3'b000};
            data = {16'b0, wdata} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'b0, wdata[7:0]} << {lane, 3'b000};
        end
        return (word & ~mask) | (data & mask);
    endfunction

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // Decode the incoming request: size, range/alignment error, effective address.
    always_comb begin
        in_op        = op_t'(req_op);
        in_half      = (in_op == OP_LH) || (in_op == OP_LHU) || (in_op == OP_SH);
        in_word      = (in_op == OP_LW) || (in_op == OP_SW);
        in_size      = in_word ? 3'd4 : (in_half ? 3'd2 : 3'd1);
        // Range check uses the address as presented, before any low-bit forcing.
        in_end       = {1'b0, req_addr} + {30'b0, in_size};
        in_range_err = in_end > 33'(MEM_BYTES);
        in_addr_eff  = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        in_misalign  = (in_half && req_addr[0]) || (in_word && (req_addr[1:0] != 2'b00));
`else
        in_misalign  = 1'b0;
        if (in_half) in_addr_eff[0]   = 1'b0;
        if (in_word) in_addr_eff[1:0] = 2'b00;
`endif
        in_err       = in_range_err || in_misalign;
    end

    // Classify the latched operation.
    always_comb begin
        lat_is_load = (lat_op == OP_LB) || (lat_op == OP_LH) || (lat_op == OP_LW) ||
                      (lat_op == OP_LBU) || (lat_op == OP_LHU);
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (in_err)               state_next = RESP;
                    else if (in_op == OP_SW)  state_next = WR;
                    else                      state_next = RD;
                end
            end
            RD:      state_next = lat_is_load ? RESP : WR;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs, decided from the upcoming state.
    // The read word is consumed at the RD exit edge: it becomes either the
    // extended load result or the merged write word, so no separate copy is kept.
    always_comb begin
        nxt_mem_read    = (state_next == RD);
        nxt_mem_write   = (state_next == WR);
        nxt_resp_valid  = (state_next == RESP);
        nxt_resp_err    = (state == IDLE) && accept && in_err;
        nxt_resp_rdata  = '0;
        nxt_mem_address = mem_address;
        nxt_mem_data_in = mem_data_in;
        if (state == IDLE) begin
            if ((state_next == RD) || (state_next == WR))
                nxt_mem_address = {in_addr_eff[31:2], 2'b00};
            if (state_next == WR)
                nxt_mem_data_in = req_wdata;
        end
        if (state == RD) begin
            if (state_next == WR)
                nxt_mem_data_in = merge_store(mem_data_out, lat_op, lat_lane, lat_wdata);
            else
                nxt_resp_rdata = extract_load(mem_data_out, lat_op, lat_lane);
        end
    end

    // Output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
        end else begin
            MemRead     <= nxt_mem_read;
            MemWrite    <= nxt_mem_write;
            mem_address <= nxt_mem_address;
            mem_data_in <= nxt_mem_data_in;
            resp_valid  <= nxt_resp_valid;
            resp_err    <= nxt_resp_err;
            resp_rdata  <= nxt_resp_rdata;
        end
    end

    // Latch the request fields needed after accept.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lat_op    <= OP_LB;
            lat_lane  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_op    <= in_op;
            lat_lane  <= in_addr_eff[1:0];
            lat_wdata <= req_wdata[15:0];
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

- Initiator side of the data-memory interface.
- Accepts one load/store request at a time from the MEM pipeline stage and drives the word-wide, byte-addressed data memory through MemRead/MemWrite.
- Handles byte, halfword and word loads (sign/zero extension) and stores; sub-word stores use read-modify-write.
- Returns one response per request, carrying load data and an error flag.

## Interface
- MEM_BYTES, 64: data memory size in bytes; a request with `addr + access_size > MEM_BYTES` is out of range.
- Clk  in  1  clock; all state changes on posedge.
- Rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high exactly when in IDLE; a request is accepted on a posedge with req_valid && req_ready.
- req_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low 8/16/32 bits used.
- resp_valid  out  1  one-cycle pulse; response fields are valid in that cycle.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  out of range, or misaligned with trap enabled.
- MemRead  out  1  memory read strobe, registered.
- MemWrite  out  1  memory write strobe, registered.
- mem_address  out  32  word-aligned byte address (`addr[1:0]` = 0), registered.
- mem_data_in  out  32  write word to memory, little-endian, registered.
- mem_data_out  in  32  read word from memory; combinational while MemRead is high.

## Operation
- Request fields are latched at accept. Lane = `addr[1:0]`. Word address = `addr & ~3`.
- Byte order: byte lane k is `word[8k+7:8k]`.
- FSM states: IDLE, RD, WR, RESP.
- IDLE, on accept:
  - error → RESP.
  - load, SB, SH → RD.
  - SW → WR.
- RD:
  - MemRead=1, mem_address=word address.
  - On the exiting posedge, capture mem_data_out.
  - Load → RESP. SB/SH → WR.
- WR:
  - MemWrite=1.
  - mem_data_in = the captured word with the selected lane(s) replaced by `req_wdata[7:0]` or `req_wdata[15:0]`; for SW it is `req_wdata`.
  - Memory writes on the exiting posedge. → RESP.
- RESP: resp_valid=1 → IDLE.
- Load extraction: the byte/halfword at the lane, sign-extended for LB/LH, zero-extended for LBU/LHU; LW takes the full word.
- MemRead and MemWrite are never high together. Each is high for exactly one cycle per access.
- Errors cause no memory access: MemRead=MemWrite=0 throughout.
- Reset values: req_ready=1 (IDLE). resp_valid, resp_err, MemRead, MemWrite = 0. resp_rdata, mem_address, mem_data_in = 0. The latched request and captured word = 0.
- Reset asserted mid-operation: outputs take reset values immediately (asynchronously); an in-flight request is dropped with no response. A store reset during RD performs no write.

## Timing
- Accept at posedge T0. All counts below are in cycles after T0, with a response of one cycle.
  - Load: RD in cycle 1, resp_valid in cycle 2.
  - SW: WR in cycle 1, resp_valid in cycle 2.
  - SB/SH: RD in cycle 1, WR in cycle 2, resp_valid in cycle 3.
  - Error: resp_valid in cycle 1.
- req_ready is low from the cycle after accept through RESP. A next request can be accepted at the posedge ending RESP.
- req_valid presented while req_ready is low is ignored and not queued; the requester must hold it.
- Back-to-back throughput: one load per 3 cycles; one SB per 4 cycles.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0, → resp_err=1, no access.
- Not defined:
  - Misaligned low bits are forced to zero: `addr[0]` for halfword, `addr[1:0]` for word.
  - The access proceeds normally with no error.
- The range check is always present.

## Test plan
- SW addr 8, wdata 0xDEADBEEF, then LW addr 8:
  - MemWrite for 1 cycle with mem_address 8, mem_data_in 0xDEADBEEF.
  - LW response resp_rdata 0xDEADBEEF, resp_err 0, in cycle 2.
- After that, LB addr 9 / LBU addr 9 / LH addr 10 / LHU addr 10 → 0xFFFFFFBE / 0x000000BE / 0xFFFFDEAD / 0x0000DEAD.
- SB addr 9, wdata 0x11, then LW addr 8:
  - RD then WR; mem_data_in 0xDEAD11EF; resp_valid in cycle 3.
  - LW returns 0xDEAD11EF.
- LW addr 62, and SW addr 64 (MEM_BYTES 64) → resp_err 1 in cycle 1, MemRead/MemWrite never high.
- LH addr 5:
  - With the macro: resp_err 1.
  - Without it: reads lane 0 of word 4, resp_err 0.
- SH addr 12 with Rst_n pulsed low during RD:
  - MemRead drops immediately, no WR occurs, no resp_valid.
  - req_ready=1 after reset, and word 12 is unchanged.
